// File: rtl/spi_bridge_pkg.sv
// Shared types and helpers for the SPI bridge blocks.
// Holds the scheduler FSM encoding, slave count and TX/RX address mapping.
package spi_bridge_pkg;

  localparam int NUM_SLAVES = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PUSH = 1'b1
  } sched_state_t;

  // An RX completion address is 0000_iii1
  localparam logic [7:0] RX_ADDR_MASK  = 8'hF1;
  localparam logic [7:0] RX_ADDR_MATCH = 8'h01;

  function automatic logic [7:0] tx_addr(input logic [2:0] idx);
    return {4'h0, idx, 1'b0};
  endfunction

  function automatic logic [2:0] rx_addr_to_idx(input logic [7:0] addr);
    return addr[3:1];
  endfunction

  function automatic logic rx_addr_ok(input logic [7:0] addr);
    return (addr & RX_ADDR_MASK) == RX_ADDR_MATCH;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NUM_SLAVES; i++)
      c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// Combinational 8-way round-robin arbiter.
// Ports: elig (request vector), ptr (last winner) -> grant_valid, grant_idx.
module rr_arbiter8
  import spi_bridge_pkg::*;
(
  input  logic [7:0] elig,
  input  logic [2:0] ptr,
  output logic       grant_valid,
  output logic [2:0] grant_idx
);

  // Search starts one past the last winner and wraps 7 -> 0.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr;
    for (int i = 1; i <= NUM_SLAVES; i++) begin
      logic [2:0] cand;
      cand = ptr + 3'(i);
      if (!grant_valid && elig[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/spi_request_scheduler.sv
// Round-robin SPI slave scheduler feeding the slave-select queue.
// Ports: requests in, SSQ push out, completions in, status/pulse flags out.
module spi_request_scheduler
  import spi_bridge_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       ACLK,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] slave_mask,
  input  logic       req_valid,
  input  logic [2:0] req_slave,
  input  logic       SSQ_full,
  output logic       SSQ_wr_en,
  output logic [7:0] SSQ_wr_addr,
  input  logic       done_en,
  input  logic [7:0] done_addr,
  output logic [7:0] pending,
  output logic [7:0] inflight,
  output logic [3:0] outstanding,
  output logic       req_merged,
  output logic       err_done
);

  localparam logic [3:0] CAP = 4'(MAX_OUTSTANDING);

  sched_state_t state;
  logic [2:0]   g;
  logic [2:0]   ptr;

  logic [7:0] elig;
  logic       can_push;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [2:0] done_idx;
  logic       done_ok;
  logic [7:0] req_vec;
  logic [7:0] push_vec;
  logic [7:0] done_vec;
  logic [7:0] pend_nxt;
  logic [7:0] infl_nxt;
  logic       merge;

  assign elig     = pending & ~inflight & slave_mask;
  assign can_push = enable & ~SSQ_full & (outstanding < CAP);
  assign done_idx = rx_addr_to_idx(done_addr);
  assign done_ok  = done_en & rx_addr_ok(done_addr)
                  & inflight[done_idx];

  assign req_vec  = req_valid ? (8'd1 << req_slave) : 8'd0;
  assign push_vec = (state == S_PUSH) ? (8'd1 << g) : 8'd0;
  assign done_vec = done_ok ? (8'd1 << done_idx) : 8'd0;

  // Sets win over the same-cycle clears.
  assign pend_nxt = (pending & ~push_vec) | req_vec;
  assign infl_nxt = (inflight & ~done_vec) | push_vec;

  // A request for the slave being consumed this cycle is a fresh one.
  assign merge = req_valid & pending[req_slave]
               & ~push_vec[req_slave];

  rr_arbiter8 u_arb (
    .elig        (elig),
    .ptr         (ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      g           <= 3'd0;
      ptr         <= 3'd7;
      SSQ_wr_en   <= 1'b0;
      SSQ_wr_addr <= 8'h00;
      pending     <= 8'h00;
      inflight    <= 8'h00;
      outstanding <= 4'd0;
      req_merged  <= 1'b0;
      err_done    <= 1'b0;
    end else begin
      pending     <= pend_nxt;
      inflight    <= infl_nxt;
      outstanding <= popcount8(infl_nxt);
      req_merged  <= merge;
      err_done    <= done_en & ~done_ok;
      unique case (state)
        S_IDLE: begin
          if (grant_valid && can_push) begin
            state       <= S_PUSH;
            g           <= grant_idx;
            SSQ_wr_en   <= 1'b1;
            SSQ_wr_addr <= tx_addr(grant_idx);
          end
        end
        S_PUSH: begin
          state     <= S_IDLE;
          SSQ_wr_en <= 1'b0;
          ptr       <= g;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_request_scheduler.sv
// Directed bench for spi_request_scheduler (MAX_OUTSTANDING=2).
// Pushes are logged on the falling edge and compared with hand-worked orders.
module tb_spi_request_scheduler;

  logic       ACLK = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] slave_mask;
  logic       req_valid;
  logic [2:0] req_slave;
  logic       SSQ_full;
  logic       SSQ_wr_en;
  logic [7:0] SSQ_wr_addr;
  logic       done_en;
  logic [7:0] done_addr;
  logic [7:0] pending;
  logic [7:0] inflight;
  logic [3:0] outstanding;
  logic       req_merged;
  logic       err_done;

  int errors = 0;
  int checks = 0;
  logic [7:0] log_q[$];

  spi_request_scheduler #(.MAX_OUTSTANDING(2)) dut (
    .ACLK        (ACLK),
    .reset       (reset),
    .enable      (enable),
    .slave_mask  (slave_mask),
    .req_valid   (req_valid),
    .req_slave   (req_slave),
    .SSQ_full    (SSQ_full),
    .SSQ_wr_en   (SSQ_wr_en),
    .SSQ_wr_addr (SSQ_wr_addr),
    .done_en     (done_en),
    .done_addr   (done_addr),
    .pending     (pending),
    .inflight    (inflight),
    .outstanding (outstanding),
    .req_merged  (req_merged),
    .err_done    (err_done)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK)
    if (SSQ_wr_en) log_q.push_back(SSQ_wr_addr);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic req(input logic [2:0] s);
    req_valid = 1'b1;
    req_slave = s;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic done(input logic [7:0] a);
    done_en   = 1'b1;
    done_addr = a;
    tick();
    done_en   = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    slave_mask = 8'hFF;
    req_valid  = 1'b0;
    req_slave  = 3'd0;
    SSQ_full   = 1'b0;
    done_en    = 1'b0;
    done_addr  = 8'h00;
    tick(2);
    chk("rst_pend", pending, 8'h00);
    chk("rst_infl", inflight, 8'h00);
    chk("rst_out", outstanding, 4'd0);
    chk("rst_wr", SSQ_wr_en, 1'b0);
    chk("rst_addr", SSQ_wr_addr, 8'h00);
    chk("rst_merge", req_merged, 1'b0);
    chk("rst_err", err_done, 1'b0);
    reset = 1'b0;
    tick();

    // single request, two-edge latency
    req(3'd3);
    chk("s_pend", pending, 8'h08);
    chk("s_wr0", SSQ_wr_en, 1'b0);
    tick();
    chk("s_wr1", SSQ_wr_en, 1'b1);
    chk("s_addr", SSQ_wr_addr, 8'h06);
    tick();
    chk("s_wr2", SSQ_wr_en, 1'b0);
    chk("s_pend2", pending, 8'h00);
    chk("s_infl", inflight, 8'h08);
    chk("s_out", outstanding, 4'd1);
    done(8'h07);
    chk("s_done", inflight, 8'h00);
    chk("s_out0", outstanding, 4'd0);
    chk("s_err", err_done, 1'b0);

    // round robin and cap of 2
    log_q.delete();
    req(3'd0);
    req(3'd5);
    req(3'd2);
    tick(6);
    chk("rr_n2", log_q.size(), 2);
    chk("rr_a0", log_q[0], 8'h00);
    chk("rr_a1", log_q[1], 8'h04);
    chk("rr_out", outstanding, 4'd2);
    chk("rr_pend", pending, 8'h20);
    done(8'h01);
    chk("rr_out1", outstanding, 4'd1);
    tick(3);
    chk("rr_n3", log_q.size(), 3);
    chk("rr_a2", log_q[2], 8'h0A);
    chk("rr_out2", outstanding, 4'd2);
    done(8'h05);
    done(8'h0B);
    chk("rr_out0", outstanding, 4'd0);

    // duplicates and in-flight re-request
    log_q.delete();
    req(3'd1);
    chk("d_merge0", req_merged, 1'b0);
    req(3'd1);
    chk("d_merge1", req_merged, 1'b1);
    tick();
    chk("d_merge2", req_merged, 1'b0);
    chk("d_pend", pending, 8'h00);
    tick(3);
    chk("d_n1", log_q.size(), 1);
    chk("d_a0", log_q[0], 8'h02);
    req(3'd1);
    tick(5);
    chk("d_hold", log_q.size(), 1);
    chk("d_pend2", pending, 8'h02);
    done(8'h03);
    chk("d_infl0", inflight, 8'h00);
    tick(3);
    chk("d_n2", log_q.size(), 2);
    chk("d_a1", log_q[1], 8'h02);
    chk("d_infl", inflight, 8'h02);
    done(8'h03);
    chk("d_out0", outstanding, 4'd0);

    // backpressure
    log_q.delete();
    SSQ_full = 1'b1;
    req(3'd0);
    req(3'd1);
    req(3'd2);
    tick(10);
    chk("bp_none", log_q.size(), 0);
    chk("bp_pend", pending, 8'h07);
    SSQ_full = 1'b0;
    tick(6);
    chk("bp_n2", log_q.size(), 2);
    chk("bp_a0", log_q[0], 8'h04);
    chk("bp_a1", log_q[1], 8'h00);
    done(8'h05);
    tick(3);
    chk("bp_n3", log_q.size(), 3);
    chk("bp_a2", log_q[2], 8'h02);
    done(8'h01);
    done(8'h03);
    chk("bp_out0", outstanding, 4'd0);

    // mask
    log_q.delete();
    slave_mask = 8'hEF;
    req(3'd4);
    tick(6);
    chk("m_none", log_q.size(), 0);
    chk("m_pend", pending, 8'h10);
    slave_mask = 8'hFF;
    tick(3);
    chk("m_n1", log_q.size(), 1);
    chk("m_a0", log_q[0], 8'h08);
    done(8'h09);
    chk("m_out0", outstanding, 4'd0);

    // bad completions
    done(8'h05);
    chk("e_err1", err_done, 1'b1);
    chk("e_out", outstanding, 4'd0);
    tick();
    chk("e_err0", err_done, 1'b0);
    done(8'h04);
    chk("e_err2", err_done, 1'b1);
    done(8'h15);
    chk("e_err3", err_done, 1'b1);
    chk("e_infl", inflight, 8'h00);

    // request during own PUSH cycle, then reset mid-PUSH
    req(3'd6);
    tick();
    chk("x_wr", SSQ_wr_en, 1'b1);
    req(3'd6);
    chk("x_pend", pending, 8'h40);
    chk("x_infl", inflight, 8'h40);
    done(8'h0D);
    tick();
    chk("x_wr2", SSQ_wr_en, 1'b1);
    chk("x_addr", SSQ_wr_addr, 8'h0C);
    #2 reset = 1'b1;
    #1;
    chk("r_wr", SSQ_wr_en, 1'b0);
    chk("r_pend", pending, 8'h00);
    chk("r_infl", inflight, 8'h00);
    chk("r_out", outstanding, 4'd0);
    #1 reset = 1'b0;
    tick(2);
    chk("r_wr2", SSQ_wr_en, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_request_scheduler.md
# spi_request_scheduler

Round-robin scheduler that decides which SPI slave is served next and feeds the slave-select queue (SSQ) read by the SPI manager. It collects per-slave transaction requests from the AXI register decode and coalesces duplicate requests. A slave with a transfer still in flight is never re-queued, and the number of outstanding queued or in-flight transfers is capped. Completion is detected from the manager's RX-register write strobe. Sits between the AXI4-Lite slave register file and the SSQ FIFO write port.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum number of slaves pushed but not yet completed. Legal range is 1..8.
- `ACLK  in  1`: single clock for the block.
- `reset  in  1`: asynchronous, active-high reset.
- `enable  in  1`: 0 stops new pushes. Tracking of in-flight transfers continues.
- `slave_mask  in  8`: bit i=1 makes slave i eligible for a grant.
- `req_valid  in  1`: one-cycle request strobe.
- `req_slave  in  3`: index of the requested slave, 0..7.
- `SSQ_full  in  1`: SSQ FIFO full flag.
- `SSQ_wr_en  out  1`: one-cycle push strobe into the SSQ.
- `SSQ_wr_addr  out  8`: TX register address of the granted slave, `{4'h0, idx, 1'b0}` (values 0x00, 0x02 … 0x0E).
- `done_en  in  1`: completion strobe, driven by the manager's `rx_reg_en`.
- `done_addr  in  8`: completion address, driven by `rx_reg_addr` (0x01, 0x03 … 0x0F).
- `pending  out  8`: per-slave flags for requests not yet pushed.
- `inflight  out  8`: per-slave flags for slaves pushed and not yet completed.
- `outstanding  out  4`: population count of `inflight`.
- `req_merged  out  1`: one-cycle pulse when a request hits a slave that is already pending.
- `err_done  out  1`: one-cycle pulse on an invalid completion.

## Operation
- **Request handling**
  - When `req_valid` is high, `pending[req_slave]` is set on the next edge.
  - If that bit is already 1, `req_merged` pulses and no other state changes.
  - A request for an in-flight slave is accepted into `pending`. It becomes eligible after that slave completes.
- **Eligibility and push permission**
  - Slave i is eligible when `pending[i] & ~inflight[i] & slave_mask[i]`.
  - A push is allowed when `enable & ~SSQ_full & (outstanding < MAX_OUTSTANDING)`.
- **FSM states:** IDLE and PUSH.
  - IDLE → PUSH when any slave is eligible and a push is allowed. The winner is latched and `SSQ_wr_en`/`SSQ_wr_addr` are registered at this transition.
  - PUSH → IDLE unconditionally after one cycle. On leaving PUSH:
    - `pending[g]` is cleared;
    - `inflight[g]` is set;
    - `outstanding` is incremented;
    - the round-robin pointer is set to g.
- **Arbitration:** round-robin. The search starts at pointer+1 and wraps 7→0. The pointer resets to 7, so slave 0 wins first.
- **Completion handling**
  - A completion is `done_en` with `done_addr[7:4]==0` and `done_addr[0]==1`. The slave index is `done_addr[3:1]`.
  - If `inflight[idx]` is 1, that bit is cleared and `outstanding` is decremented.
  - Otherwise `err_done` pulses and nothing changes; `outstanding` never underflows.
  - `done_en` with any other address pulses `err_done` and nothing changes.
- **Simultaneous events**
  - A request and the PUSH clear for the same slave in one cycle: set wins, so `pending` stays 1.
  - A completion and a push in one cycle: `outstanding` is unchanged net. If both target the same slave, which is impossible by construction, set wins.
  - A completion and a request for the same slave in one cycle: both take effect.
- **Masking and disable**
  - A masked slave keeps its `pending` bit. It is served after it is unmasked.
  - Deasserting `enable` while in PUSH lets that push complete.

## Timing
- **Reset values:**
  - FSM in IDLE;
  - `pending`, `inflight` and `outstanding` all 0;
  - `SSQ_wr_en`=0 and `SSQ_wr_addr`=0x00;
  - `req_merged` and `err_done` both 0;
  - pointer = 7.
- **Reset mid-operation:** reset asserted during PUSH drops `SSQ_wr_en` immediately (asynchronously). Queued requests are lost.
- **Latency:** a request sampled at edge E0 produces `SSQ_wr_en` high from E1 to E2, with the FIFO capturing it at E2. That is two edges from request to FIFO write.
- **Throughput:** at most one push every 2 cycles. `SSQ_full` is re-evaluated in IDLE after every push, so a FIFO with at least 1 free slot is never overrun.
- **Output registration:** all outputs are registered.
- **Status update timing:** `pending`, `inflight` and `outstanding` update on the same edge as their cause.

## Structure
- **Shared package `spi_bridge_pkg`:**
  - FSM state encoding;
  - `NUM_SLAVES`=8;
  - functions `tx_addr(idx)` and `rx_addr_to_idx(addr)`;
  - a constant for the RX-address validity check.
- **Sub-module `rr_arbiter8`:** combinational round-robin arbiter. Inputs are the 8-bit eligibility vector and the 3-bit pointer; outputs are `grant_valid` and the 3-bit `grant_idx`. It is reusable by other bridge blocks.

## Test plan
- **Single request:** reset, `slave_mask`=0xFF, `enable`=1, request slave 3 → `SSQ_wr_en` for one cycle at E1 with addr 0x06. After that push, `pending`=0x00, `inflight`=0x08, `outstanding`=1. Then `done_en` with 0x07 → `inflight`=0x00.
- **Round robin and cap:** requests for slaves 0, 5, 2 in consecutive cycles → pushes 0x00, 0x04, 0x0A in that order. With `MAX_OUTSTANDING`=2, the third push waits until `done_addr`=0x01 arrives.
- **Duplicates and in-flight:** request slave 1 twice → one push plus a `req_merged` pulse. Request slave 1 again while it is in flight → no push until 0x03 completes, then a push of 0x02.
- **Backpressure and mask:** `SSQ_full`=1 for 10 cycles with 3 slaves pending → no `SSQ_wr_en`, pushes resume after `full` falls. Slave 4 masked while pending → never pushed until the mask is set, then 0x08.
- **Errors:** `done_en` with 0x05 while slave 2 is idle → `err_done` pulse, `outstanding` stays 0. `done_en` with 0x04 → `err_done` pulse.
- **Reset and simultaneous events:**
  - Reset asserted during PUSH → `SSQ_wr_en` falls asynchronously and all status is 0.
  - A request for slave 6 in the PUSH cycle of slave 6 → `pending[6]` remains 1.
